// File: rtl/reg_bank_2r1w.sv
// reg_bank_2r1w: DEPTH x DATA_W register bank with one write port and two
// independent registered read ports. Reads return the post-edge contents of
// the entry, so a same-edge write or sweep clear is bypassed to the reader.
// Each entry has a sticky write lock (cleared only by reset), and a
// hardware sequencer sweeps the bank clearing one unlocked entry per cycle.

// Property checker for the bank's externally visible invariants.
module reg_bank_2r1w_checker #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input logic              clk,
  input logic              rst,
  input logic              wr_en,
  input logic              wr_err,
  input logic              busy,
  input logic [DEPTH-1:0]  lock_status,
  input logic              rd_valid_a,
  input logic [DATA_W-1:0] rd_data_a,
  input logic              rd_valid_b,
  input logic [DATA_W-1:0] rd_data_b
);

  // A rejected-write flag can only follow a cycle that requested a write.
  a_wr_err_needs_wr: assert property (@(posedge clk) disable iff (!rst)
    !wr_en |=> !wr_err);

  // Lock bits never drop outside of reset.
  a_lock_sticky: assert property (@(posedge clk)
    rst |=> ((lock_status & $past(lock_status)) == $past(lock_status)));

  // Reset always leaves the sequencer idle.
  a_reset_idle: assert property (@(posedge clk)
    !rst |=> !busy);

  // Idle read ports present zero data.
  a_rd_a_idle_zero: assert property (@(posedge clk)
    !rd_valid_a |-> (rd_data_a == '0));
  a_rd_b_idle_zero: assert property (@(posedge clk)
    !rd_valid_b |-> (rd_data_b == '0));

endmodule

module reg_bank_2r1w #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              lock_set,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_err,
  output logic [DEPTH-1:0]  lock_status
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  // Pointer value of the final sweep step.
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  // One-hot entry select; addresses at or beyond DEPTH select nothing,
  // which is what makes out-of-range writes, locks and reads inert.
  function automatic logic [DEPTH-1:0] entry_sel(input logic [ADDR_W-1:0] addr);
    logic [DEPTH-1:0] sel;
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = (addr == ADDR_W'(i));
    end
    return sel;
  endfunction

  // AND-OR mux over the entries; an empty select yields zero.
  function automatic logic [DATA_W-1:0] entry_read(
    input logic [DEPTH-1:0]             sel,
    input logic [DEPTH-1:0][DATA_W-1:0] arr
  );
    logic [DATA_W-1:0] data;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        data = data | arr[i];
      end else begin
        data = data;
      end
    end
    return data;
  endfunction

  state_t                      state_r;
  state_t                      state_nxt_s;
  logic [ADDR_W-1:0]           ptr_r;
  logic [ADDR_W-1:0]           ptr_nxt_s;
  logic [DEPTH-1:0][DATA_W-1:0] mem_r;
  logic [DEPTH-1:0][DATA_W-1:0] mem_nxt_s;
  logic [DEPTH-1:0]            lock_r;
  logic [DEPTH-1:0]            lock_nxt_s;
  logic [DEPTH-1:0]            wr_sel_s;
  logic [DEPTH-1:0]            clr_sel_s;
  logic [DEPTH-1:0]            rd_sel_a_s;
  logic [DEPTH-1:0]            rd_sel_b_s;
  logic                        wr_accept_s;
  logic [DATA_W-1:0]           rd_data_a_r;
  logic                        rd_valid_a_r;
  logic [DATA_W-1:0]           rd_data_b_r;
  logic                        rd_valid_b_r;
  logic                        busy_r;
  logic                        wr_err_r;

  // Decode all addresses and decide whether this cycle's write lands.
  always_comb begin
    wr_sel_s   = entry_sel(wr_addr);
    rd_sel_a_s = entry_sel(rd_addr_a);
    rd_sel_b_s = entry_sel(rd_addr_b);
    if (state_r == S_CLEAR) begin
      // Locked entries survive the sweep, judged on the pre-edge lock bits.
      clr_sel_s = entry_sel(ptr_r) & ~lock_r;
    end else begin
      clr_sel_s = '0;
    end
    wr_accept_s = wr_en && (state_r == S_IDLE) && (|wr_sel_s) &&
                  !(|(wr_sel_s & lock_r));
  end

  // Post-edge entry contents: accepted write, else sweep clear, else hold.
  always_comb begin
    mem_nxt_s = mem_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_accept_s && wr_sel_s[i]) begin
        mem_nxt_s[i] = wr_data;
      end else if (clr_sel_s[i]) begin
        mem_nxt_s[i] = '0;
      end else begin
        mem_nxt_s[i] = mem_r[i];
      end
    end
  end

  // Lock bits only ever accumulate; the write decision above already used
  // the old bits, so a same-cycle write+lock lands before the lock closes.
  always_comb begin
    lock_nxt_s = lock_r;
    if (lock_set) begin
      lock_nxt_s = lock_r | wr_sel_s;
    end else begin
      lock_nxt_s = lock_r;
    end
  end

  // Clear sequencer next-state: one entry per cycle, no restart mid-sweep.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      S_IDLE: begin
        if (clr_req) begin
          state_nxt_s = S_CLEAR;
          ptr_nxt_s   = '0;
        end else begin
          state_nxt_s = S_IDLE;
          ptr_nxt_s   = ptr_r;
        end
      end
      S_CLEAR: begin
        if (ptr_r == LAST_PTR) begin
          state_nxt_s = S_IDLE;
          ptr_nxt_s   = '0;
        end else begin
          state_nxt_s = S_CLEAR;
          ptr_nxt_s   = ptr_r + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        ptr_nxt_s   = '0;
      end
    endcase
  end

  // Sequencer state and sweep pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_IDLE;
      ptr_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // Storage, locks and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_r        <= '0;
      lock_r       <= '0;
      rd_data_a_r  <= '0;
      rd_valid_a_r <= 1'b0;
      rd_data_b_r  <= '0;
      rd_valid_b_r <= 1'b0;
      busy_r       <= 1'b0;
      wr_err_r     <= 1'b0;
    end else begin
      mem_r        <= mem_nxt_s;
      lock_r       <= lock_nxt_s;
      rd_valid_a_r <= rd_en_a;
      rd_data_a_r  <= rd_en_a ? entry_read(rd_sel_a_s, mem_nxt_s) : '0;
      rd_valid_b_r <= rd_en_b;
      rd_data_b_r  <= rd_en_b ? entry_read(rd_sel_b_s, mem_nxt_s) : '0;
      busy_r       <= (state_nxt_s == S_CLEAR);
      wr_err_r     <= wr_en && !wr_accept_s;
    end
  end

  assign rd_data_a   = rd_data_a_r;
  assign rd_valid_a  = rd_valid_a_r;
  assign rd_data_b   = rd_data_b_r;
  assign rd_valid_b  = rd_valid_b_r;
  assign busy        = busy_r;
  assign wr_err      = wr_err_r;
  assign lock_status = lock_r;

  reg_bank_2r1w_checker #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_err     (wr_err_r),
    .busy       (busy_r),
    .lock_status(lock_r),
    .rd_valid_a (rd_valid_a_r),
    .rd_data_a  (rd_data_a_r),
    .rd_valid_b (rd_valid_b_r),
    .rd_data_b  (rd_data_b_r)
  );

endmodule

// File: tb/tb_reg_bank_2r1w.sv
// Self-checking bench for reg_bank_2r1w, DEPTH=5 / ADDR_W=3 so that both
// the non-power-of-two depth and unmapped addresses are reachable.
module tb_reg_bank_2r1w;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AW    = 3;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          lock_set;
  logic          rd_en_a;
  logic [AW-1:0] rd_addr_a;
  logic [DW-1:0] rd_data_a;
  logic          rd_valid_a;
  logic          rd_en_b;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_b;
  logic          rd_valid_b;
  logic          clr_req;
  logic          busy;
  logic          wr_err;
  logic [DEPTH-1:0] lock_status;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  reg_bank_2r1w #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_set(lock_set), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a), .rd_en_b(rd_en_b),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .clr_req(clr_req), .busy(busy), .wr_err(wr_err), .lock_status(lock_status)
  );

  initial clk = 1'b0;
  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus, queue the read results it must produce, advance one edge.
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic ls, input logic clr,
                       input logic rea, input logic [AW-1:0] ra,
                       input logic reb, input logic [AW-1:0] rb,
                       input logic [DW-1:0] exp_a, input logic [DW-1:0] exp_b);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd; lock_set = ls; clr_req = clr;
    rd_en_a = rea; rd_addr_a = ra; rd_en_b = reb; rd_addr_b = rb;
    e.v = rea; e.d = rea ? exp_a : 8'h00; q_a.push_back(e);
    e.v = reb; e.d = reb ? exp_b : 8'h00; q_b.push_back(e);
    tick();
  endtask

  task automatic test_reset();
    exp_t ea, eb;
    rst = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00; lock_set = 1'b0;
    clr_req = 1'b0; rd_en_a = 1'b0; rd_addr_a = 3'd0; rd_en_b = 1'b0; rd_addr_b = 3'd0;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0 || lock_status !== 5'b00000 || wr_err !== 1'b0 ||
        rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0)
      $display("FAIL reset_state: busy=%b lock=%b wr_err=%b va=%b vb=%b, expected all 0",
               busy, lock_status, wr_err, rd_valid_a, rd_valid_b);
    else n_pass++;
    rst = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, AW'(a), (a == 0), 3'd0, 8'h00, 8'h00);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      n_checks++;
      if (rd_valid_a !== ea.v || rd_data_a !== ea.d)
        $display("FAIL reset_rd_a addr=%0d: got v=%b d=%h, expected v=%b d=%h", a, rd_valid_a, rd_data_a, ea.v, ea.d);
      else n_pass++;
      n_checks++;
      if (rd_valid_b !== eb.v || rd_data_b !== eb.d)
        $display("FAIL reset_rd_b addr=%0d: got v=%b d=%h, expected v=%b d=%h", a, rd_valid_b, rd_data_b, eb.v, eb.d);
      else n_pass++;
    end
  endtask

  task automatic test_bypass();
    exp_t ea, eb;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) drive(1'b1, 3'd2, 8'hA5, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 3'd1, 8'hA5, 8'h00);
      else        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2, 8'hA5, 8'hA5);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      n_checks++;
      if (rd_valid_a !== ea.v || rd_data_a !== ea.d)
        $display("FAIL bypass_rd_a step=%0d: got v=%b d=%h, expected v=%b d=%h", s, rd_valid_a, rd_data_a, ea.v, ea.d);
      else n_pass++;
      n_checks++;
      if (rd_valid_b !== eb.v || rd_data_b !== eb.d)
        $display("FAIL bypass_rd_b step=%0d: got v=%b d=%h, expected v=%b d=%h", s, rd_valid_b, rd_data_b, eb.v, eb.d);
      else n_pass++;
      n_checks++;
      if (wr_err !== 1'b0) $display("FAIL bypass_wr_err step=%0d: got %b, expected 0", s, wr_err);
      else n_pass++;
    end
  endtask

  task automatic test_lock();
    exp_t ea, eb;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0:       drive(1'b1, 3'd1, 8'h3C, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
        1:       drive(1'b1, 3'd1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
        default: drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 3'd1, 8'h3C, 8'h3C);
      endcase
      ea = q_a.pop_front(); eb = q_b.pop_front();
      n_checks++;
      if (rd_valid_a !== ea.v || rd_data_a !== ea.d || rd_valid_b !== eb.v || rd_data_b !== eb.d)
        $display("FAIL lock_rd step=%0d: got a=%b/%h b=%b/%h, expected a=%b/%h b=%b/%h",
                 s, rd_valid_a, rd_data_a, rd_valid_b, rd_data_b, ea.v, ea.d, eb.v, eb.d);
      else n_pass++;
      n_checks++;
      if (wr_err !== (s == 1)) $display("FAIL lock_wr_err step=%0d: got %b, expected %b", s, wr_err, (s == 1));
      else n_pass++;
      n_checks++;
      if (lock_status !== 5'b00010) $display("FAIL lock_status step=%0d: got %b, expected 00010", s, lock_status);
      else n_pass++;
    end
  endtask

  task automatic test_clear();
    exp_t ea, eb;
    logic [DW-1:0] fill_d [4];
    logic [AW-1:0] fill_a [4];
    logic [DW-1:0] after [5];
    int nb;
    fill_a = '{3'd0, 3'd2, 3'd3, 3'd4};
    fill_d = '{8'h11, 8'h33, 8'h44, 8'h55};
    after  = '{8'h00, 8'h3C, 8'h00, 8'h44, 8'h00};
    // Entry 1 is already locked; entry 3 is written and locked in the same cycle.
    for (int s = 0; s < 5; s++) begin
      if (s < 4) drive(1'b1, fill_a[s], fill_d[s], (s == 2), 1'b0, 1'b0, 3'd0, 1'b1, fill_a[s], 8'h00, fill_d[s]);
      else       drive(1'b1, 3'd3, 8'h99, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 8'h00, 8'h44);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      n_checks++;
      if (rd_valid_b !== eb.v || rd_data_b !== eb.d)
        $display("FAIL fill_rd_b step=%0d: got v=%b d=%h, expected v=%b d=%h", s, rd_valid_b, rd_data_b, eb.v, eb.d);
      else n_pass++;
      n_checks++;
      if (wr_err !== (s == 4)) $display("FAIL fill_wr_err step=%0d: got %b, expected %b", s, wr_err, (s == 4));
      else n_pass++;
    end
    n_checks++;
    if (lock_status !== 5'b01010) $display("FAIL fill_lock_status: got %b, expected 01010", lock_status);
    else n_pass++;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    nb = 0;
    for (int k = 0; k < 20 && busy === 1'b1; k++) begin
      nb++;
      case (k)
        1:       drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
        2:       drive(1'b1, 3'd0, 8'h99, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 3'd4, 8'h00, 8'h55);
        default: drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
      endcase
      ea = q_a.pop_front(); eb = q_b.pop_front();
      n_checks++;
      if (rd_valid_a !== ea.v || rd_data_a !== ea.d || rd_valid_b !== eb.v || rd_data_b !== eb.d)
        $display("FAIL sweep_rd k=%0d: got a=%b/%h b=%b/%h, expected a=%b/%h b=%b/%h",
                 k, rd_valid_a, rd_data_a, rd_valid_b, rd_data_b, ea.v, ea.d, eb.v, eb.d);
      else n_pass++;
      n_checks++;
      if (wr_err !== (k == 2)) $display("FAIL sweep_wr_err k=%0d: got %b, expected %b", k, wr_err, (k == 2));
      else n_pass++;
    end
    n_checks++;
    if (nb != DEPTH) $display("FAIL sweep_busy_cycles: got %0d, expected %0d", nb, DEPTH);
    else n_pass++;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, AW'(a), 1'b1, AW'(a), after[a], after[a]);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      n_checks++;
      if (rd_valid_a !== ea.v || rd_data_a !== ea.d || rd_valid_b !== eb.v || rd_data_b !== eb.d)
        $display("FAIL after_sweep_rd addr=%0d: got a=%b/%h b=%b/%h, expected %b/%h",
                 a, rd_valid_a, rd_data_a, rd_valid_b, rd_data_b, ea.v, ea.d);
      else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    exp_t ea, eb;
    logic [DW-1:0] kept [5];
    kept = '{8'h00, 8'h3C, 8'h00, 8'h44, 8'h00};
    drive(1'b1, 3'd6, 8'h77, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 3'd5, 8'h00, 8'h00);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    n_checks++;
    if (rd_valid_a !== ea.v || rd_data_a !== ea.d || rd_valid_b !== eb.v || rd_data_b !== eb.d)
      $display("FAIL oor_rd: got a=%b/%h b=%b/%h, expected a=%b/%h b=%b/%h",
               rd_valid_a, rd_data_a, rd_valid_b, rd_data_b, ea.v, ea.d, eb.v, eb.d);
    else n_pass++;
    n_checks++;
    if (wr_err !== 1'b1 || lock_status !== 5'b01010)
      $display("FAIL oor_write: got wr_err=%b lock=%b, expected wr_err=1 lock=01010", wr_err, lock_status);
    else n_pass++;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, AW'(a), 1'b1, 3'd6, kept[a], 8'h00);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      n_checks++;
      if (rd_valid_a !== ea.v || rd_data_a !== ea.d || rd_valid_b !== eb.v || rd_data_b !== eb.d)
        $display("FAIL oor_kept addr=%0d: got a=%b/%h b=%b/%h, expected a=%b/%h b=%b/%h",
                 a, rd_valid_a, rd_data_a, rd_valid_b, rd_data_b, ea.v, ea.d, eb.v, eb.d);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    exp_t ea, eb;
    int nb;
    drive(1'b1, 3'd4, 8'h5A, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL mid_sweep_busy: got %b, expected 1", busy);
    else n_pass++;
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    rst = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || lock_status !== 5'b00000 || wr_err !== 1'b0)
      $display("FAIL abort_state: got busy=%b lock=%b wr_err=%b, expected 0/00000/0", busy, lock_status, wr_err);
    else n_pass++;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, AW'(a), 1'b0, 3'd0, 8'h00, 8'h00);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      n_checks++;
      if (rd_valid_a !== ea.v || rd_data_a !== ea.d)
        $display("FAIL abort_rd addr=%0d: got v=%b d=%h, expected v=%b d=%h", a, rd_valid_a, rd_data_a, ea.v, ea.d);
      else n_pass++;
    end
    drive(1'b1, 3'd4, 8'h5A, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    nb = 0;
    for (int k = 0; k < 20 && busy === 1'b1; k++) begin
      nb++;
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
      ea = q_a.pop_front(); eb = q_b.pop_front();
    end
    n_checks++;
    if (nb != DEPTH) $display("FAIL fresh_sweep_cycles: got %0d, expected %0d", nb, DEPTH);
    else n_pass++;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 8'h00, 8'h00);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    n_checks++;
    if (rd_valid_a !== ea.v || rd_data_a !== ea.d)
      $display("FAIL fresh_sweep_rd: got v=%b d=%h, expected v=%b d=%h", rd_valid_a, rd_data_a, ea.v, ea.d);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_lock();
    test_clear();
    test_out_of_range();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
